// File: rtl/rob_completion_arbiter.sv
// rob_completion_arbiter: round-robin arbitration of execution-unit completions onto the ROB completion port.
// Registered output stage with valid/ready handshake, flush squash and a saturating stall counter.
// Optional build macro RCA_EXC_PRIO_EN: completions raising an exception win ahead of the others.
module rob_completion_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int TAG_WIDTH       = 6,
    parameter int SRC_WIDTH       = $clog2(NUM_REQ),
    parameter int STALL_CNT_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*TAG_WIDTH-1:0]   req_tag,
    input  logic [NUM_REQ-1:0]             req_exc,
    output logic                           cmpl_valid,
    input  logic                           cmpl_ready,
    output logic [TAG_WIDTH-1:0]           cmpl_tag,
    output logic                           cmpl_exc,
    output logic [SRC_WIDTH-1:0]           cmpl_src,
    input  logic                           flush,
    output logic [STALL_CNT_WIDTH-1:0]     stall_cnt
);

    logic [SRC_WIDTH-1:0] rr_ptr;
    logic [SRC_WIDTH-1:0] win;
    logic [NUM_REQ-1:0]   cand;
    logic                 any;
    logic                 load_en;
    logic                 grant;

`ifdef RCA_EXC_PRIO_EN
    assign cand = |(req_valid & req_exc) ? (req_valid & req_exc) : req_valid;
`else
    assign cand = req_valid;
`endif

    assign load_en   = !flush && (!cmpl_valid || cmpl_ready);
    assign grant     = rst_n && load_en && any;
    assign req_ready = grant ? NUM_REQ'(1) << win : '0;

    // Scan candidates from rr_ptr upward with wrap; descending loop lets the nearest one win.
    always_comb begin
        any = 1'b0;
        win = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (cand[(int'(rr_ptr) + k) % NUM_REQ]) begin
                any = 1'b1;
                win = SRC_WIDTH'((int'(rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    // Output register, round-robin pointer and stall counter; flush drops the held entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmpl_valid <= 1'b0;
            cmpl_tag   <= '0;
            cmpl_exc   <= 1'b0;
            cmpl_src   <= '0;
            rr_ptr     <= '0;
            stall_cnt  <= '0;
        end else begin
            if (flush) begin
                cmpl_valid <= 1'b0;
            end else if (grant) begin
                cmpl_valid <= 1'b1;
                cmpl_tag   <= req_tag[int'(win)*TAG_WIDTH +: TAG_WIDTH];
                cmpl_exc   <= req_exc[win];
                cmpl_src   <= win;
                rr_ptr     <= (win == SRC_WIDTH'(NUM_REQ - 1)) ? '0 : win + 1'b1;
            end else if (cmpl_ready) begin
                cmpl_valid <= 1'b0;
            end
            if (cmpl_valid && !cmpl_ready && !flush && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_rob_completion_arbiter.sv
// tb_rob_completion_arbiter: directed bench for rob_completion_arbiter with hand-computed expectations.
module tb_rob_completion_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [23:0] req_tag;
    logic [3:0]  req_exc;
    logic        cmpl_valid;
    logic        cmpl_ready;
    logic [5:0]  cmpl_tag;
    logic        cmpl_exc;
    logic [1:0]  cmpl_src;
    logic        flush;
    logic [15:0] stall_cnt;
    logic [5:0]  tag_arr [4];
    int          total = 0;
    int          bad = 0;

    assign req_tag = {tag_arr[3], tag_arr[2], tag_arr[1], tag_arr[0]};

    rob_completion_arbiter dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_tag(req_tag), .req_exc(req_exc), .cmpl_valid(cmpl_valid),
        .cmpl_ready(cmpl_ready), .cmpl_tag(cmpl_tag), .cmpl_exc(cmpl_exc),
        .cmpl_src(cmpl_src), .flush(flush), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req_valid = 4'b1111; req_exc = 4'b0000; cmpl_ready = 1'b1; flush = 1'b0;
        for (int i = 0; i < 4; i++) tag_arr[i] = 6'h20 + 6'(i);
        repeat (2) tick;
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
        total++; if (cmpl_valid !== 1'b0) begin bad++; $display("FAIL reset_cmpl_valid got=%b exp=0", cmpl_valid); end
        total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cnt); end
        total++; if (cmpl_tag !== 6'd0 || cmpl_src !== 2'd0 || cmpl_exc !== 1'b0) begin bad++; $display("FAIL reset_outputs got tag=%h src=%0d exc=%b exp 0", cmpl_tag, cmpl_src, cmpl_exc); end
        rst_n = 1'b1;
        #1;
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL release_first_grant got=%b exp=0001", req_ready); end
        tick;
        total++; if (cmpl_valid !== 1'b1 || cmpl_src !== 2'd0 || cmpl_tag !== 6'h20) begin bad++; $display("FAIL release_load got v=%b src=%0d tag=%h exp v=1 src=0 tag=20", cmpl_valid, cmpl_src, cmpl_tag); end
    endtask

    task automatic test_fairness;
        for (int k = 0; k < 5; k++) begin
            tick;
            total++;
            if (cmpl_valid !== 1'b1 || cmpl_src !== 2'((k + 1) % 4) || cmpl_tag !== 6'h20 + 6'((k + 1) % 4)) begin
                bad++; $display("FAIL fairness_step%0d got v=%b src=%0d tag=%h exp v=1 src=%0d", k, cmpl_valid, cmpl_src, cmpl_tag, (k + 1) % 4);
            end
        end
        req_valid = 4'b0000;
        tick;
        total++; if (cmpl_valid !== 1'b0) begin bad++; $display("FAIL fairness_drain got=%b exp=0", cmpl_valid); end
    endtask

    task automatic test_backpressure;
        tag_arr[2] = 6'h15; tag_arr[1] = 6'h21; req_valid = 4'b0100; cmpl_ready = 1'b0;
        #1;
        total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL bp_first_grant got=%b exp=0100", req_ready); end
        tick;
        req_valid = 4'b0010;
        #1;
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL bp_ready_blocked got=%b exp=0000", req_ready); end
        for (int k = 0; k < 5; k++) begin
            tick;
            total++; if (cmpl_valid !== 1'b1 || cmpl_tag !== 6'h15 || cmpl_src !== 2'd2) begin bad++; $display("FAIL bp_hold%0d got v=%b tag=%h src=%0d exp v=1 tag=15 src=2", k, cmpl_valid, cmpl_tag, cmpl_src); end
        end
        total++; if (stall_cnt !== 16'd5) begin bad++; $display("FAIL bp_stall_cnt got=%0d exp=5", stall_cnt); end
        cmpl_ready = 1'b1;
        #1;
        total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL bp_accept_grant got=%b exp=0010", req_ready); end
        tick;
        total++; if (cmpl_valid !== 1'b1 || cmpl_src !== 2'd1 || cmpl_tag !== 6'h21) begin bad++; $display("FAIL bp_no_bubble got v=%b src=%0d tag=%h exp v=1 src=1 tag=21", cmpl_valid, cmpl_src, cmpl_tag); end
        total++; if (stall_cnt !== 16'd5) begin bad++; $display("FAIL bp_stall_after got=%0d exp=5", stall_cnt); end
        req_valid = 4'b0000;
        tick;
        total++; if (cmpl_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b exp=0", cmpl_valid); end
    endtask

    task automatic test_wrap;
        req_valid = 4'b0100;
        tick;
        req_valid = 4'b1001;
        #1;
        total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL wrap_grant3 got=%b exp=1000", req_ready); end
        tick;
        total++; if (cmpl_src !== 2'd3) begin bad++; $display("FAIL wrap_src3 got=%0d exp=3", cmpl_src); end
        req_valid = 4'b0001;
        #1;
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL wrap_grant0 got=%b exp=0001", req_ready); end
        tick;
        total++; if (cmpl_src !== 2'd0) begin bad++; $display("FAIL wrap_src0 got=%0d exp=0", cmpl_src); end
        req_valid = 4'b1001;
        #1;
        total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL wrap_ptr_is1 got=%b exp=1000", req_ready); end
        tick;
        req_valid = 4'b0000;
        tick;
        total++; if (cmpl_valid !== 1'b0) begin bad++; $display("FAIL wrap_drain got=%b exp=0", cmpl_valid); end
    endtask

    task automatic test_flush;
        req_valid = 4'b0001;
        tick;
        flush = 1'b1; cmpl_ready = 1'b1; req_valid = 4'b0010;
        #1;
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL flush_no_grant got=%b exp=0000", req_ready); end
        tick;
        total++; if (cmpl_valid !== 1'b0) begin bad++; $display("FAIL flush_drop got=%b exp=0", cmpl_valid); end
        flush = 1'b0;
        #1;
        total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL flush_after_grant got=%b exp=0010", req_ready); end
        tick;
        total++; if (cmpl_valid !== 1'b1 || cmpl_src !== 2'd1) begin bad++; $display("FAIL flush_after_load got v=%b src=%0d exp v=1 src=1", cmpl_valid, cmpl_src); end
        req_valid = 4'b0000; cmpl_ready = 1'b0; flush = 1'b1;
        tick;
        total++; if (cmpl_valid !== 1'b0 || stall_cnt !== 16'd5) begin bad++; $display("FAIL flush_no_stall got v=%b stall=%0d exp v=0 stall=5", cmpl_valid, stall_cnt); end
        flush = 1'b0; cmpl_ready = 1'b1;
    endtask

    task automatic test_exc_prio;
        logic [3:0] exp_first;
        logic [1:0] exp_src;
        req_valid = 4'b1000;
        tick;
        req_valid = 4'b0000;
        tick;
        req_valid = 4'b0101; req_exc = 4'b0100;
`ifdef RCA_EXC_PRIO_EN
        exp_first = 4'b0100; exp_src = 2'd2;
`else
        exp_first = 4'b0001; exp_src = 2'd0;
`endif
        #1;
        total++; if (req_ready !== exp_first) begin bad++; $display("FAIL exc_first_grant got=%b exp=%b", req_ready, exp_first); end
        tick;
        total++; if (cmpl_src !== exp_src || cmpl_exc !== (exp_src == 2'd2)) begin bad++; $display("FAIL exc_first_load got src=%0d exc=%b exp src=%0d", cmpl_src, cmpl_exc, exp_src); end
        req_valid = 4'b0101 & ~exp_first;
        tick;
        total++; if (cmpl_src !== 2'd2 - exp_src || cmpl_exc !== (exp_src == 2'd0)) begin bad++; $display("FAIL exc_second_load got src=%0d exc=%b exp src=%0d", cmpl_src, cmpl_exc, 2'd2 - exp_src); end
        req_valid = 4'b0000; req_exc = 4'b0000;
        tick;
    endtask

    initial begin
        test_reset;
        test_fairness;
        test_backpressure;
        test_wrap;
        test_flush;
        test_exc_prio;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rob_completion_arbiter.md
# rob_completion_arbiter

Arbitrates completion reports from NUM_REQ execution units onto the single completion port of the reorder buffer, which marks one entry ready per cycle. Round-robin fairness, one registered output stage with valid/ready handshake toward the ROB, and a flush input that discards in-flight completions on a pipeline squash. Sits between the functional-unit writeback buses and the ROB completion/ready-set logic.

## Interface
- NUM_REQ, 4, number of completion requesters (2..8)
- TAG_WIDTH, 6, ROB tag width
- SRC_WIDTH, $clog2(NUM_REQ), requester index width
- STALL_CNT_WIDTH, 16, width of stall performance counter

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  NUM_REQ  requester i has a completion pending
- req_ready  out  NUM_REQ  requester i's completion accepted this cycle
- req_tag  in  NUM_REQ*TAG_WIDTH  tag of requester i at bits [i*TAG_WIDTH +: TAG_WIDTH]
- req_exc  in  NUM_REQ  completion of requester i raised an exception
- cmpl_valid  out  1  output stage holds a completion
- cmpl_ready  in  1  ROB accepts the completion
- cmpl_tag  out  TAG_WIDTH  tag of held completion
- cmpl_exc  out  1  exception flag of held completion
- cmpl_src  out  SRC_WIDTH  index of requester that produced it
- flush  in  1  squash: drop held completion and all grants this cycle
- stall_cnt  out  STALL_CNT_WIDTH  saturating count of cycles with cmpl_valid && !cmpl_ready

## Operation
- State: output register (valid, tag, exc, src), round-robin pointer rr_ptr (SRC_WIDTH), stall_cnt.
- load_en = !flush && (!cmpl_valid || cmpl_ready).
- Winner: first i with req_valid[i] scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ (wraps NUM_REQ-1 -> 0).
- req_ready[winner] = load_en; all other req_ready = 0. At most one req_ready high; combinational from req_valid, rr_ptr, cmpl_valid, cmpl_ready, flush.
- On grant: output register loads winner's tag/exc/src, cmpl_valid <= 1; rr_ptr <= winner+1 mod NUM_REQ.
- ROB accepts with no new grant: cmpl_valid <= 0. Accept and new grant same cycle: register replaced, no bubble.
- No grant: rr_ptr unchanged.
- flush: cmpl_valid <= 0 next cycle regardless of cmpl_ready; no grant; rr_ptr unchanged; stall_cnt unchanged.
- stall_cnt increments when cmpl_valid && !cmpl_ready && !flush; saturates at all-ones; never clears except reset.
- Requesters hold req_valid/req_tag/req_exc stable until req_ready; arbiter does not check.

## Timing
- Reset: cmpl_valid=0, cmpl_tag=0, cmpl_exc=0, cmpl_src=0, rr_ptr=0, stall_cnt=0; req_ready=0 while rst_n low.
- Latency: grant in cycle N -> cmpl_valid at N+1. Throughput one completion per cycle with cmpl_ready held high.
- Output stable while cmpl_valid && !cmpl_ready.
- Reset mid-operation: held completion lost; pending requests re-arbitrate from index 0 after release.
- flush and cmpl_ready same cycle: flush wins; the completion counts as dropped, not delivered.

## Configuration
- RCA_EXC_PRIO_EN defined: requests with req_exc=1 take priority; winner = first exception requester in round-robin order from rr_ptr, else first non-exception requester in round-robin order; rr_ptr still updates to winner+1.
- Undefined: pure round-robin, req_exc only passed through to cmpl_exc.

## Test plan
- Reset: hold rst_n low with req_valid=4'b1111 -> req_ready=0, cmpl_valid=0, stall_cnt=0; release -> first grant index 0.
- Fairness: req_valid=4'b1111 constant, cmpl_ready=1 -> cmpl_src sequence 0,1,2,3,0 on consecutive cycles, no bubbles.
- Backpressure: one completion tag=0x15 held, cmpl_ready=0 for 5 cycles -> cmpl_tag stays 0x15, req_ready=0, stall_cnt=5; cmpl_ready=1 -> delivered, next grant same cycle.
- Wrap: rr_ptr=3, req_valid=4'b1001 -> grant 3 then 0; rr_ptr becomes 0 then 1.
- Flush: cmpl_valid=1, flush=1 with cmpl_ready=1 and req_valid=4'b0010 -> cmpl_valid=0 next cycle, req_ready=0 during flush, requester 1 granted the cycle after.
- Exception priority (RCA_EXC_PRIO_EN): rr_ptr=0, req_valid=4'b0101, req_exc=4'b0100 -> requester 2 granted first, cmpl_exc=1; without macro requester 0 first.
